// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch slice: FSM encodings, word widths,
// the queue entry layout and PC helpers.
package instr_fetch_unit_pkg;

    localparam int          INSTR_W = 16;
    localparam logic [15:0] PC_STEP = 16'd2;

    typedef enum logic [1:0] {
        FS_IDLE = 2'b00,
        FS_REQ  = 2'b01,
        FS_DROP = 2'b10
    } fetch_state_e;

    typedef struct packed {
        logic [15:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Instructions are halfword aligned; an odd target is pulled down to the even address.
    function automatic logic [15:0] align_pc(input logic [15:0] pc);
        return pc & 16'hFFFE;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle around the fetch unit: instruction-memory port, decode port and branch redirect.
//   imem: req is held high with a stable addr until the cycle ack=1; rdata is valid only in
//         that ack cycle. ack while req=0 carries no meaning.
//   ir:   the head transfers on any rising edge where ir_valid & ir_ready; ir_valid never
//         depends on ir_ready, and ir/ir_pc stay stable while ir_valid & ~ir_ready.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic               imem_req;
    logic [15:0]        imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               ir_valid;
    logic               ir_ready;
    logic [INSTR_W-1:0] ir;
    logic [15:0]        ir_pc;
    logic               redirect;
    logic [15:0]        redirect_pc;

    modport master (
        output imem_req, imem_addr, ir_valid, ir, ir_pc,
        input  imem_ack, imem_rdata, ir_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, ir, ir_pc,
        output imem_ack, imem_rdata, ir_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of {pc, instr} between the memory side and decode.
// Synchronous flush clears it in one cycle and wins over a same-cycle push.
module instr_fetch_unit_fetch_queue
    import instr_fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop & ~empty;
    assign head   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Front end of the 16-bit CPU: owns the PC, fetches words over req/ack into a small queue
// and hands them to decode; branch redirects flush the queue and squash in-flight fetches.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                clock,
    input  logic                reset,
    instr_fetch_unit_if.master  bus,
    output fetch_state_e        fsm_state
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e  state_q, state_d;
    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic [15:0]   req_addr_q;

    fetch_entry_t  push_data;
    fetch_entry_t  head;
    logic          push;
    logic          pop;
    logic          flush;
    logic [CW-1:0] count;
    logic          q_empty;
    logic          q_full;
    logic [CW:0]   count_after_push;

    instr_fetch_unit_fetch_queue #(.DEPTH(DEPTH)) u_fetch_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .count     (count),
        .empty     (q_empty),
        .full      (q_full)
    );

    // Next-state logic. A new request is only issued when its word already has a slot, so
    // the queue can never overflow while a fetch is outstanding.
    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        push             = 1'b0;
        flush            = bus.redirect;
        pop              = ~q_empty & bus.ir_ready;
        push_data.pc     = fetch_pc_q;
        push_data.instr  = bus.imem_rdata;
        count_after_push = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);

        case (state_q)
            FS_IDLE: begin
                if (!bus.redirect && (count < CW'(DEPTH))) begin
                    state_d = FS_REQ;
                end
            end
            FS_REQ: begin
                if (bus.redirect) begin
                    state_d = bus.imem_ack ? FS_IDLE : FS_DROP;
                end else if (bus.imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    state_d    = (count_after_push < (CW+1)'(DEPTH)) ? FS_REQ : FS_IDLE;
                end
            end
            FS_DROP: begin
                if (bus.imem_ack) begin
                    state_d = FS_IDLE;
                end
            end
            default: state_d = FS_IDLE;
        endcase

        if (bus.redirect) begin
            fetch_pc_d = align_pc(bus.redirect_pc);
        end
    end

    // req_addr_q freezes the squashed request's address while fetch_pc already follows the branch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FS_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if (state_d != FS_DROP) begin
                req_addr_q <= fetch_pc_d;
            end
        end
    end

    assign bus.imem_req  = (state_q == FS_REQ) || (state_q == FS_DROP);
    assign bus.imem_addr = (state_q == FS_DROP) ? req_addr_q : fetch_pc_q;
    assign bus.ir_valid  = ~q_empty;
    assign bus.ir        = q_empty ? '0 : head.instr;
    assign bus.ir_pc     = q_empty ? 16'h0000 : head.pc;
    assign fsm_state     = state_q;

    no_push_when_full: assert property (@(posedge clock) disable iff (reset || flush)
        !(push && q_full));

endmodule
